// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, load-use stalls,
// branch flushes and data-memory wait handling. Optional perf counters via HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemTimeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] StallCnt,
  output logic [PERF_W-1:0] FlushCnt,
  output logic [PERF_W-1:0] MemWaitCnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  if (MEM_TIMEOUT < 1) begin : gBadTimeout
    $error("MEM_TIMEOUT must be >= 1");
  end
  if (PERF_W < 1) begin : gBadPerfW
    $error("PERF_W must be >= 1");
  end

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t             state, nextState;
  logic [CNT_W-1:0]   waitCnt, nextWaitCnt;
  logic               timeoutQ, nextTimeout;

  logic lwStall, memBusy, freeze;

  function automatic logic [1:0] fwdSel(input logic [4:0] rs);
    if (RegWriteM && RdM != 5'd0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
    else                                            return 2'b00;
  endfunction

  assign lwStall = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
  assign memBusy = MemReqM && !MemReadyM;
  assign freeze  = memBusy || (state == ERROR);

  // State register. Nothing here is a memory array, so every flop gets a reset value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      waitCnt  <= '0;
      timeoutQ <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state    <= nextState;
      waitCnt  <= nextWaitCnt;
      timeoutQ <= nextTimeout;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
    nextState   = state;
    nextWaitCnt = waitCnt;
    nextTimeout = timeoutQ;
    unique case (state)
      RUN: begin
        if (memBusy) begin
          nextState   = MEM_WAIT;
          nextWaitCnt = CNT_W'(1);
        end else begin
          nextWaitCnt = '0;
        end
      end
      MEM_WAIT: begin
        // A completed or withdrawn request both end the wait without error.
        if (MemReadyM || !MemReqM) begin
          nextState   = RUN;
          nextWaitCnt = '0;
        end else if (waitCnt == CNT_W'(MEM_TIMEOUT)) begin
          nextState   = ERROR;
          nextTimeout = 1'b1;
        end else begin
          nextWaitCnt = waitCnt + 1'b1;
        end
      end
      ERROR: begin
        nextState = ERROR;
      end
      default: begin
        nextState   = RUN;
        nextWaitCnt = '0;
      end
    endcase
  end

  // Outputs; held at zero while reset is asserted.
  always_comb begin
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;
    MemTimeout = 1'b0;
    if (rst) begin
      ForwardAE  = fwdSel(Rs1E);
      ForwardBE  = fwdSel(Rs2E);
      MemTimeout = timeoutQ;
      if (freeze) begin
        // Branch flush and load-use bubble wait: D/E are held and re-evaluate on release.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lwStall;
        StallD = lwStall;
        FlushE = lwStall | PCSrcE;
        FlushD = PCSrcE;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      StallCnt   <= '0;
      FlushCnt   <= '0;
      MemWaitCnt <= '0;
    end else begin
      if (lwStall && !freeze) StallCnt   <= StallCnt + 1'b1;
      if (PCSrcE && !freeze)  FlushCnt   <= FlushCnt + 1'b1;
      if (freeze)             MemWaitCnt <= MemWaitCnt + 1'b1;
    end
  end
`endif

endmodule
